// File: rtl/uart_rx_drain.sv
// uart_rx_drain
// Bus-master drain engine for the buffered UART receiver. Polls the
// receiver status register, pops bytes from its data register, packs them
// little-endian into 32-bit words and writes the words to memory through a
// ready/valid write port. A drain ends on word count, idle timeout,
// receiver error or abort, and signals completion with a DONE pulse.
//
// Optional feature: define RX_DRAIN_TERM_EN to end the drain when a byte
// equal to TERM_CHAR is received. That byte is stored with the word before
// the drain ends. With the macro undefined, TERM_CHAR is ignored.
//
// Ports
//   CLK, RESET_N         clock, synchronous active-low reset
//   START, ABORT         begin drain (pulse), stop at next safe point
//   BASE_ADDR            first word address (bits [1:0] forced to 0)
//   MAX_WORDS            words to collect, 0 = unlimited
//   TIMEOUT              empty polls before finishing, 0 = never
//   TERM_CHAR            terminator byte (RX_DRAIN_TERM_EN only)
//   RX_RE/RX_WE/RX_A     receiver read strobe, write strobe, address (1=status)
//   RX_RD                receiver read data (combinational on RX_A)
//   MEM_WE/ADDR/WD/BE    memory write request, held until MEM_READY
//   MEM_READY            write accepted this cycle
//   BUSY, DONE, ERR      status: in progress, completion pulse, sticky error
//   WORD_COUNT           words written in the current or last drain
//
// state  | meaning
// IDLE   | waiting for START
// POLL   | read status, choose error / abort / pop / idle count
// POP    | read one byte from the FIFO head into the current lane
// WRITE  | hold memory write until accepted
// FLUSH  | write any partial word, then finish
// CLEAR  | clear receiver flags and FIFO after an error
// FIN    | DONE pulse, back to IDLE

module uart_rx_drain #(
  parameter int LW = 12,
  parameter int TW = 16
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          START,
  input  logic          ABORT,
  input  logic [31:0]   BASE_ADDR,
  input  logic [LW-1:0] MAX_WORDS,
  input  logic [TW-1:0] TIMEOUT,
  input  logic [7:0]    TERM_CHAR,
  output logic          RX_RE,
  output logic          RX_WE,
  output logic          RX_A,
  input  logic [31:0]   RX_RD,
  output logic          MEM_WE,
  output logic [31:0]   MEM_ADDR,
  output logic [31:0]   MEM_WD,
  output logic [3:0]    MEM_BE,
  input  logic          MEM_READY,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [LW-1:0] WORD_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_POP,
    S_WRITE,
    S_FLUSH,
    S_CLEAR,
    S_FIN
  } state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] max_words_q;
  logic [TW-1:0] timeout_q;
  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] idle_inc;
  logic [1:0]    lane;
  logic          from_flush;
  logic [LW-1:0] cnt_inc;
  logic [LW-1:0] cnt_sat;
  logic          last_word;
  logic          rx_err;
  logic          rx_not_empty;
  logic          term_hit;
  logic          unused_rd;

  assign rx_err       = RX_RD[30] | RX_RD[29];
  assign rx_not_empty = RX_RD[31];
  assign unused_rd    = ^RX_RD[28:8];

  assign idle_inc  = idle_cnt + TW'(1);
  assign cnt_inc   = WORD_COUNT + LW'(1);
  assign cnt_sat   = (&WORD_COUNT) ? WORD_COUNT : cnt_inc;
  assign last_word = (max_words_q != '0) && (cnt_inc == max_words_q);

`ifdef RX_DRAIN_TERM_EN
  assign term_hit = (RX_RD[7:0] == TERM_CHAR);
`else
  logic unused_term;
  assign unused_term = ^TERM_CHAR;
  assign term_hit    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    RX_RE     = 1'b0;
    RX_WE     = 1'b0;
    RX_A      = 1'b0;
    MEM_WE    = 1'b0;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) state_nxt = S_POLL;
      end
      S_POLL: begin
        RX_A = 1'b1;
        if (rx_err)            state_nxt = S_CLEAR;
        else if (ABORT)        state_nxt = S_FLUSH;
        else if (rx_not_empty) state_nxt = S_POP;
        else if ((timeout_q != '0) && (idle_inc == timeout_q))
                               state_nxt = S_FLUSH;
      end
      S_POP: begin
        RX_RE = 1'b1;
        // a terminator in the last lane still completes the word via WRITE;
        // from_flush then routes WRITE to FIN
        if (lane == 2'd3)  state_nxt = S_WRITE;
        else if (term_hit) state_nxt = S_FLUSH;
        else               state_nxt = S_POLL;
      end
      S_WRITE: begin
        MEM_WE = 1'b1;
        if (MEM_READY) begin
          if (last_word || from_flush) state_nxt = S_FIN;
          else                         state_nxt = S_POLL;
        end
      end
      S_FLUSH: begin
        if (MEM_BE != 4'h0) state_nxt = S_WRITE;
        else                state_nxt = S_FIN;
      end
      S_CLEAR: begin
        RX_A      = 1'b1;
        RX_WE     = 1'b1;
        state_nxt = S_FIN;
      end
      S_FIN: begin
        BUSY      = 1'b0;
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      max_words_q <= '0;
      timeout_q   <= '0;
      idle_cnt    <= '0;
      lane        <= 2'd0;
      from_flush  <= 1'b0;
      MEM_ADDR    <= 32'd0;
      MEM_WD      <= 32'd0;
      MEM_BE      <= 4'h0;
      ERR         <= 1'b0;
      WORD_COUNT  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            max_words_q <= MAX_WORDS;
            timeout_q   <= TIMEOUT;
            idle_cnt    <= '0;
            lane        <= 2'd0;
            from_flush  <= 1'b0;
            MEM_ADDR    <= {BASE_ADDR[31:2], 2'b00};
            MEM_WD      <= 32'd0;
            MEM_BE      <= 4'h0;
            ERR         <= 1'b0;
            WORD_COUNT  <= '0;
          end
        end
        S_POLL: begin
          if (!rx_err && !ABORT) begin
            if (rx_not_empty) idle_cnt <= '0;
            else              idle_cnt <= idle_inc;
          end
        end
        S_POP: begin
          MEM_WD[{lane, 3'b000} +: 8] <= RX_RD[7:0];
          MEM_BE[lane]                <= 1'b1;
          lane                        <= lane + 2'd1;
          if (term_hit) from_flush <= 1'b1;
        end
        S_WRITE: begin
          if (MEM_READY) begin
            WORD_COUNT <= cnt_sat;
            MEM_ADDR   <= MEM_ADDR + 32'd4;
            MEM_WD     <= 32'd0;
            MEM_BE     <= 4'h0;
          end
        end
        S_FLUSH: begin
          from_flush <= 1'b1;
        end
        S_CLEAR: begin
          ERR    <= 1'b1;
          MEM_WD <= 32'd0;
          MEM_BE <= 4'h0;
          lane   <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_drain.sv
// Testbench for uart_rx_drain: behavioural receiver FIFO model, scoreboard
// of expected memory writes, one task per scenario.
module tb_uart_rx_drain;
  localparam int LW = 12;
  localparam int TW = 16;

  logic          CLK = 1'b0;
  logic          RESET_N, START, ABORT;
  logic [31:0]   BASE_ADDR;
  logic [LW-1:0] MAX_WORDS;
  logic [TW-1:0] TIMEOUT;
  logic [7:0]    TERM_CHAR;
  logic          RX_RE, RX_WE, RX_A;
  logic [31:0]   RX_RD;
  logic          MEM_WE;
  logic [31:0]   MEM_ADDR, MEM_WD;
  logic [3:0]    MEM_BE;
  logic          MEM_READY;
  logic          BUSY, DONE, ERR;
  logic [LW-1:0] WORD_COUNT;

  always #5 CLK = ~CLK;

  uart_rx_drain #(.LW(LW), .TW(TW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT),
    .TERM_CHAR(TERM_CHAR), .RX_RE(RX_RE), .RX_WE(RX_WE), .RX_A(RX_A),
    .RX_RD(RX_RD), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WD(MEM_WD),
    .MEM_BE(MEM_BE), .MEM_READY(MEM_READY), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .WORD_COUNT(WORD_COUNT)
  );

  // receiver model
  logic [7:0] fifo [256];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  logic       ovf = 1'b0;
  logic       par = 1'b0;
  logic       push_req = 1'b0;
  logic [7:0] push_data = 8'd0;
  logic       set_ovf_req = 1'b0;
  logic [7:0] fill;

  assign fill  = wp - rp;
  assign RX_RD = RX_A ? {(fill != 8'd0), ovf, par, 21'd0, fill} : {24'd0, fifo[rp]};

  always @(posedge CLK) begin
    if (push_req) begin
      fifo[wp] <= push_data;
      wp <= wp + 8'd1;
    end
    if (RX_RE && fill != 8'd0) rp <= rp + 8'd1;
    if (RX_WE && RX_A) begin
      rp  <= wp;
      ovf <= 1'b0;
      par <= 1'b0;
    end
    if (set_ovf_req) ovf <= 1'b1;
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   stall_left = 0;
  bit   abort_in_stall = 0;
  int   rxwe_cnt = 0;
  int   pops = 0;
  int   ovf_after = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;
  int   done_cyc = 0;
  bit   snap_valid = 0;
  logic [67:0] snap;
  bit   done_seen;

  task automatic push(input logic [7:0] b);
    @(negedge CLK);
    push_req  = 1'b1;
    push_data = b;
    @(negedge CLK);
    push_req  = 1'b0;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.a = a; e.d = d; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic start_drain(input logic [31:0] base, input logic [LW-1:0] mw, input logic [TW-1:0] tmo);
    @(negedge CLK);
    BASE_ADDR = base;
    MAX_WORDS = mw;
    TIMEOUT   = tmo;
    START     = 1'b1;
    @(negedge CLK);
    START     = 1'b0;
  endtask

  // Steps the clock, drives MEM_READY, and pops/compares the scoreboard on
  // every accepted write. Returns when DONE is seen, on MEM_WE if asked,
  // or when the budget runs out.
  task automatic run(input int budget, input bit stop_on_we, output bit seen);
    wr_t e;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      cyc++;
      set_ovf_req = 1'b0;
      if (RX_RE || RX_WE) begin
        tests++;
        if ((RX_RE && RX_WE) || (RX_WE && !RX_A)) begin
          fails++;
          $display("FAIL rx_strobes: RE=%b WE=%b A=%b, required one strobe, A=1 with WE", RX_RE, RX_WE, RX_A);
        end
      end
      if (RX_WE) rxwe_cnt++;
      if (RX_RE) begin
        pops++;
        last_pop_cyc = cyc;
        if (pops == ovf_after) set_ovf_req = 1'b1;
      end
      if (MEM_WE) begin
        if (stall_left > 0) begin
          MEM_READY = 1'b0;
          stall_left--;
          if (abort_in_stall) ABORT = 1'b1;
          if (!snap_valid) begin
            snap = {MEM_ADDR, MEM_WD, MEM_BE};
            snap_valid = 1;
          end else begin
            tests++;
            if ({MEM_ADDR, MEM_WD, MEM_BE} !== snap) begin
              fails++;
              $display("FAIL stall_stable: got %h, required %h", {MEM_ADDR, MEM_WD, MEM_BE}, snap);
            end
          end
        end else begin
          MEM_READY  = 1'b1;
          snap_valid = 0;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr=%h data=%h be=%h, required no write", MEM_ADDR, MEM_WD, MEM_BE);
          end else begin
            e = exp_q.pop_front();
            if (MEM_ADDR !== e.a || MEM_WD !== e.d || MEM_BE !== e.be) begin
              fails++;
              $display("FAIL mem_write: got %h/%h/%h, required %h/%h/%h",
                       MEM_ADDR, MEM_WD, MEM_BE, e.a, e.d, e.be);
            end
          end
        end
        if (stop_on_we) break;
      end else begin
        MEM_READY = 1'b1;
      end
      if (DONE) begin
        seen = 1;
        done_cyc = cyc;
        tests++;
        if (BUSY !== 1'b0) begin
          fails++;
          $display("FAIL busy_at_done: got %b, required 0", BUSY);
        end
        break;
      end
    end
  endtask

  task automatic finish_checks(input string name, input bit seen, input logic [LW-1:0] wc, input logic err);
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_done: DONE not seen within budget, required DONE", name);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_pending: %0d writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge CLK);
    tests++;
    if (WORD_COUNT !== wc || ERR !== err || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL %s_status: count=%0d err=%b busy=%b, required count=%0d err=%b busy=0",
               name, WORD_COUNT, ERR, BUSY, wc, err);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    tests++;
    if ({RX_RE, RX_WE, RX_A, MEM_WE, BUSY, DONE, ERR} !== 7'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 0000000", {RX_RE, RX_WE, RX_A, MEM_WE, BUSY, DONE, ERR});
    end
    tests++;
    if (MEM_ADDR !== 32'd0 || MEM_WD !== 32'd0 || MEM_BE !== 4'd0 || WORD_COUNT !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h/%h/%0d, required zeros", MEM_ADDR, MEM_WD, MEM_BE, WORD_COUNT);
    end
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_max_words();
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    expect_wr(32'h100, 32'h14131211, 4'hF);
    expect_wr(32'h104, 32'h18171615, 4'hF);
    start_drain(32'h100, 12'd2, 16'd0);
    run(200, 0, done_seen);
    finish_checks("max_words", done_seen, 12'd2, 1'b0);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 6; i++) push(8'h01 + 8'(i));
    expect_wr(32'h0, 32'h04030201, 4'hF);
    expect_wr(32'h4, 32'h00000605, 4'h3);
    start_drain(32'h0, 12'd0, 16'd50);
    run(300, 0, done_seen);
    tests++;
    if (done_cyc - last_pop_cyc != 53) begin
      fails++;
      $display("FAIL timeout_latency: got %0d cycles, required 53", done_cyc - last_pop_cyc);
    end
    finish_checks("timeout", done_seen, 12'd2, 1'b0);
  endtask

  task automatic test_error();
    push(8'h31);
    push(8'h32);
    pops = 0;
    rxwe_cnt = 0;
    ovf_after = 2;
    start_drain(32'h300, 12'd0, 16'd0);
    run(100, 0, done_seen);
    ovf_after = 0;
    tests++;
    if (rxwe_cnt != 1) begin
      fails++;
      $display("FAIL error_clear_strobe: got %0d RX_WE cycles, required 1", rxwe_cnt);
    end
    finish_checks("error", done_seen, 12'd0, 1'b1);
    start_drain(32'h0, 12'd0, 16'd5);
    tests++;
    if (ERR !== 1'b0 || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL error_restart: err=%b busy=%b, required err=0 busy=1", ERR, BUSY);
    end
    run(50, 0, done_seen);
    finish_checks("error_restart", done_seen, 12'd0, 1'b0);
  endtask

  task automatic test_stall_abort();
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    expect_wr(32'h200, 32'h24232221, 4'hF);
    pops = 0;
    stall_left = 10;
    abort_in_stall = 1;
    start_drain(32'h200, 12'd0, 16'd0);
    run(100, 0, done_seen);
    ABORT = 1'b0;
    abort_in_stall = 0;
    tests++;
    if (pops != 4) begin
      fails++;
      $display("FAIL stall_pops: got %0d reads, required 4", pops);
    end
    finish_checks("stall_abort", done_seen, 12'd1, 1'b0);
  endtask

  task automatic test_reset_in_write();
    for (int i = 0; i < 4; i++) push(8'h51 + 8'(i));
    stall_left = 1000;
    start_drain(32'h400, 12'd0, 16'd0);
    run(100, 1, done_seen);
    tests++;
    if (MEM_WE !== 1'b1) begin
      fails++;
      $display("FAIL rst_write_reach: MEM_WE=%b, required 1", MEM_WE);
    end
    RESET_N = 1'b0;
    @(negedge CLK);
    tests++;
    if (MEM_WE !== 1'b0 || BUSY !== 1'b0 || WORD_COUNT !== '0 || MEM_ADDR !== 32'd0 || MEM_BE !== 4'd0) begin
      fails++;
      $display("FAIL rst_write: we=%b busy=%b count=%0d addr=%h be=%h, required all 0",
               MEM_WE, BUSY, WORD_COUNT, MEM_ADDR, MEM_BE);
    end
    RESET_N = 1'b1;
    stall_left = 0;
    snap_valid = 0;
    MEM_READY = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    expect_wr(32'h500, 32'h64636261, 4'hF);
    start_drain(32'h500, 12'd1, 16'd0);
    run(100, 0, done_seen);
    finish_checks("rst_restart", done_seen, 12'd1, 1'b0);
  endtask

  task automatic test_back_to_back_wrap();
    for (int i = 0; i < 8; i++) push(8'h71 + 8'(i));
    expect_wr(32'hFFFF_FFFC, 32'h74737271, 4'hF);
    expect_wr(32'h0000_0000, 32'h78777675, 4'hF);
    start_drain(32'hFFFF_FFFD, 12'd2, 16'd0);
    run(200, 0, done_seen);
    finish_checks("addr_wrap", done_seen, 12'd2, 1'b0);
  endtask

  task automatic test_term();
    push(8'h41);
    push(8'h42);
    push(8'h0A);
    expect_wr(32'h0, 32'h000A4241, 4'h7);
`ifdef RX_DRAIN_TERM_EN
    start_drain(32'h0, 12'd0, 16'd0);
`else
    start_drain(32'h0, 12'd0, 16'd10);
`endif
    run(100, 0, done_seen);
    finish_checks("term", done_seen, 12'd1, 1'b0);
  endtask

  initial begin
    RESET_N   = 1'b0;
    START     = 1'b0;
    ABORT     = 1'b0;
    BASE_ADDR = 32'd0;
    MAX_WORDS = '0;
    TIMEOUT   = '0;
    TERM_CHAR = 8'h0A;
    MEM_READY = 1'b1;
    test_reset();
    test_max_words();
    test_timeout();
    test_error();
    test_stall_abort();
    test_reset_in_write();
    test_back_to_back_wrap();
    test_term();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_drain.md
Name: uart_rx_drain

Overview:
Bus-master controller that empties the buffered UART receiver without CPU polling. It reads the receiver's status/data register pair and packs received bytes little-endian into 32-bit words. Words are written to memory through a simple ready/valid write port. The drain ends on word count, idle timeout, error or abort, and finishes with a done pulse for the interrupt controller.

Parameters:
LW, 12, width of MAX_WORDS and WORD_COUNT
TW, 16, width of TIMEOUT and idle counter

Ports:
CLK  in  1  clock
RESET_N  in  1  synchronous active-low reset
START  in  1  one-cycle pulse; begin drain (ignored while BUSY)
ABORT  in  1  stop at next safe point
BASE_ADDR  in  32  first word address; bits [1:0] ignored (treated 0)
MAX_WORDS  in  LW  words to collect; 0 = unlimited
TIMEOUT  in  TW  idle cycles (FIFO empty) before finishing; 0 = never
TERM_CHAR  in  8  terminator byte (used only with optional feature)
RX_RE  out  1  receiver read strobe
RX_WE  out  1  receiver write strobe (with RX_A=1: clear flags and flush FIFO)
RX_A  out  1  receiver address: 1 = status, 0 = data
RX_RD  in  32  receiver read data (combinational); status [31]=not empty, [30]=overflow, [29]=parity error, [7:0]=fill; data [7:0]=FIFO head
MEM_WE  out  1  write request; held until MEM_READY
MEM_ADDR  out  32  word-aligned write address
MEM_WD  out  32  write data
MEM_BE  out  4  byte enables
MEM_READY  in  1  write accepted this cycle
BUSY  out  1  drain in progress
DONE  out  1  one-cycle pulse at completion
ERR  out  1  sticky: last drain ended on receiver error; cleared by START
WORD_COUNT  out  LW  words written in current or last drain (partial word counts)

Behaviour:
- Reset: state IDLE. Zero on all outputs: RX_RE, RX_WE, RX_A, MEM_WE, MEM_ADDR, MEM_WD, MEM_BE, BUSY, DONE, ERR, WORD_COUNT. Byte lane index 0. Idle counter 0.
- IDLE: START latches MAX_WORDS and TIMEOUT. It also sets MEM_ADDR=BASE_ADDR&~3, clears WORD_COUNT, ERR, lane and idle counter, and sets BUSY. Next state POLL.
- POLL: RX_A=1; sample RX_RD. Checks run in this priority order:
  - [30]|[29] set -> CLEAR.
  - ABORT -> FLUSH.
  - [31] set -> POP; idle counter cleared.
  - Else idle counter +1. When the counter reaches TIMEOUT (TIMEOUT≠0) -> FLUSH.
- POP: RX_A=0, RX_RE=1 for exactly one cycle. RX_RD[7:0] is stored into MEM_WD lane `lane`, and MEM_BE[lane] is set.
  - If lane==3: lane wraps to 0 and the next state is WRITE.
  - Otherwise lane+1 and back to POLL.
  - Throughput is one byte per 2 cycles.
- WRITE: MEM_WE=1, with MEM_ADDR, MEM_WD and MEM_BE held stable until MEM_READY.
  - On MEM_READY: WORD_COUNT+1, MEM_ADDR+4, MEM_WD and MEM_BE cleared.
  - If WORD_COUNT+1==MAX_WORDS (MAX_WORDS≠0), or the write was entered from FLUSH: -> FIN. Else -> POLL.
  - ABORT during WRITE is deferred: the write completes, then POLL sees ABORT.
- FLUSH: if MEM_BE≠0, go to WRITE (the partial word is written with only the valid lanes enabled). Else FIN.
- CLEAR: RX_A=1, RX_WE=1 for one cycle; this clears the flags and flushes the receiver FIFO. ERR set. Any partial word is discarded (MEM_BE cleared). -> FIN.
- FIN: DONE=1 for one cycle, BUSY=0. -> IDLE.
- RX_RE and RX_WE are never asserted together. RX_A is driven 0 whenever neither strobe is active outside POLL.
- MEM_ADDR wraps modulo 2^32. WORD_COUNT saturates at all-ones when MAX_WORDS=0.
- RESET_N low in any state returns to IDLE on that edge. MEM_WE drops immediately; an in-flight write is abandoned.

Optional Feature:
Macro RX_DRAIN_TERM_EN.
- Defined: in POP, a byte equal to TERM_CHAR is stored normally, then forces FLUSH. The partial or full word is written, then FIN. If lane==3, go to WRITE and then FIN.
- Undefined: TERM_CHAR is ignored and no comparator is built.

Test Plan:
- START, BASE_ADDR=0x100, MAX_WORDS=2; bytes 11..18 arrive. Expect writes 0x100←0x14131211 BE=F and 0x104←0x18171615 BE=F, then DONE, WORD_COUNT=2, ERR=0.
- MAX_WORDS=0, TIMEOUT=50; 6 bytes 01..06, then idle. After 50 empty polls expect writes 0x04030201 BE=F and 0x00000605 BE=3, DONE, WORD_COUNT=2.
- Overflow flag set mid-word (2 bytes captured). Expect one RX_WE cycle with RX_A=1, no memory write, ERR=1, DONE. A subsequent START clears ERR.
- MEM_READY held low for 10 cycles. MEM_WE and its address/data/BE stay stable; no RX_RE occurs until acceptance. ABORT asserted meanwhile: the write completes, then DONE.
- RESET_N low during WRITE. The next cycle shows MEM_WE=0, BUSY=0, WORD_COUNT=0. A START afterwards behaves as from power-up.
- RX_DRAIN_TERM_EN, TERM_CHAR=0x0A; bytes 41 42 0A. Expect a single write 0x000A4241 BE=7, then DONE.
